// File: rtl/aud_play_ctrl.sv
// rtl/aud_play_ctrl.sv - playback sequencer between SRAM read port and I2S DAC player
//
// Fetches one PCM sample per DAC frame and applies speed control: fast mode
// strides the address by 2^speed, slow mode holds each sample for 2^speed
// frames (repeated or linearly interpolated). Handles start, pause, resume,
// stop and end-of-recording.
//
// Ports:
//   i_bclk, i_rst        bit clock, asynchronous active-high reset
//   i_daclrck            DAC LR clock; its rising edge is the frame tick
//   i_start/i_pause/i_stop  commands (stop > pause > start)
//   i_speed/i_fast/i_interp/i_end_addr  configuration, latched on start/resume
//   o_rd_req/o_rd_addr, i_rd_valid/i_rd_data  SRAM read handshake
//   o_player_en, o_dac_data  player enable and held output sample
//   o_done               one-cycle pulse at end of recording
//   o_state              0 IDLE, 1 FETCH, 2 WAIT, 3 PAUSE
module aud_play_ctrl #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
) (
   input  logic              i_bclk,
   input  logic              i_rst,
   input  logic              i_daclrck,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_stop,
   input  logic [1:0]        i_speed,
   input  logic              i_fast,
   input  logic              i_interp,
   input  logic [ADDR_W-1:0] i_end_addr,
   output logic              o_rd_req,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic              i_rd_valid,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_player_en,
   output logic [DATA_W-1:0] o_dac_data,
   output logic              o_done,
   output logic [1:0]        o_state
);

   // Product of the 17-bit difference and the 3-bit phase fits in DATA_W+4 bits.
   localparam int PW = DATA_W + 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2,
      ST_PAUSE = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic                daclrck_q;
   logic [ADDR_W-1:0]   addr, addr_nxt;
   logic [DATA_W-1:0]   prev, prev_nxt;
   logic [DATA_W-1:0]   cur, cur_nxt;
   logic [2:0]          k, k_nxt;
   logic [DATA_W-1:0]   dac_data, dac_data_nxt;
   logic                player_en, player_en_nxt;
   logic                done, done_nxt;
   logic                pause_pend, pause_pend_nxt;
   logic [1:0]          speed_r, speed_nxt;
   logic                fast_r, fast_nxt;
   logic                interp_r, interp_nxt;
   logic [ADDR_W-1:0]   end_r, end_nxt;

   logic                tick;
   logic [3:0]          n_factor;
   logic [ADDR_W:0]     nxt_addr;
   logic                last_phase;
   logic signed [DATA_W:0] diff;
   logic signed [PW-1:0]   diff_w;
   logic signed [PW-1:0]   k_w;
   logic signed [PW-1:0]   prod;
   logic signed [PW-1:0]   scaled;
   logic [DATA_W-1:0]   out_sample;

   assign tick     = i_daclrck & ~daclrck_q;
   assign n_factor = 4'd1 << speed_r;

   // One bit wider than the address so a stride past the top cannot wrap
   // back below end_addr.
   assign nxt_addr = {1'b0, addr} + (fast_r ? {{(ADDR_W-3){1'b0}}, n_factor}
                                            : {{ADDR_W{1'b0}}, 1'b1});

   // >= rather than == keeps a resume at a smaller speed from running k past N-1.
   assign last_phase = fast_r || ({1'b0, k} >= (n_factor - 4'd1));

   // prev + ((cur - prev) * k) >>> s; the result lies between prev and cur so
   // truncating back to DATA_W bits cannot overflow.
   assign diff   = $signed({cur[DATA_W-1], cur}) - $signed({prev[DATA_W-1], prev});
   assign diff_w = {{3{diff[DATA_W]}}, diff};
   assign k_w    = $signed({{(PW-3){1'b0}}, k});
   assign prod   = diff_w * k_w;
   assign scaled = prod >>> speed_r;

   always_comb begin
      out_sample = cur;
      if (!fast_r && interp_r) begin
         out_sample = prev + scaled[DATA_W-1:0];
      end
   end

   always_ff @(posedge i_bclk or posedge i_rst) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         daclrck_q  <= 1'b0;
         addr       <= '0;
         prev       <= '0;
         cur        <= '0;
         k          <= '0;
         dac_data   <= '0;
         player_en  <= 1'b0;
         done       <= 1'b0;
         pause_pend <= 1'b0;
         speed_r    <= '0;
         fast_r     <= 1'b0;
         interp_r   <= 1'b0;
         end_r      <= '0;
      end else begin
         state      <= state_nxt;
         daclrck_q  <= i_daclrck;
         addr       <= addr_nxt;
         prev       <= prev_nxt;
         cur        <= cur_nxt;
         k          <= k_nxt;
         dac_data   <= dac_data_nxt;
         player_en  <= player_en_nxt;
         done       <= done_nxt;
         pause_pend <= pause_pend_nxt;
         speed_r    <= speed_nxt;
         fast_r     <= fast_nxt;
         interp_r   <= interp_nxt;
         end_r      <= end_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      addr_nxt       = addr;
      prev_nxt       = prev;
      cur_nxt        = cur;
      k_nxt          = k;
      dac_data_nxt   = dac_data;
      player_en_nxt  = player_en;
      done_nxt       = 1'b0;
      pause_pend_nxt = pause_pend;
      speed_nxt      = speed_r;
      fast_nxt       = fast_r;
      interp_nxt     = interp_r;
      end_nxt        = end_r;

      if (i_stop) begin
         state_nxt      = ST_IDLE;
         addr_nxt       = '0;
         player_en_nxt  = 1'b0;
         dac_data_nxt   = '0;
         pause_pend_nxt = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               player_en_nxt = 1'b0;
               if (i_start && !i_pause) begin
                  speed_nxt      = i_speed;
                  fast_nxt       = i_fast;
                  interp_nxt     = i_interp;
                  end_nxt        = i_end_addr;
                  addr_nxt       = '0;
                  prev_nxt       = '0;
                  k_nxt          = '0;
                  pause_pend_nxt = 1'b0;
                  state_nxt      = ST_FETCH;
               end
            end
            ST_FETCH: begin
               // A pause during a read is remembered and applied when the data lands.
               if (i_pause) begin
                  pause_pend_nxt = 1'b1;
               end
               if (i_rd_valid) begin
                  cur_nxt = i_rd_data;
                  if (i_pause || pause_pend) begin
                     pause_pend_nxt = 1'b0;
                     player_en_nxt  = 1'b0;
                     state_nxt      = ST_PAUSE;
                  end else begin
                     player_en_nxt = 1'b1;
                     state_nxt     = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (i_pause) begin
                  player_en_nxt = 1'b0;
                  state_nxt     = ST_PAUSE;
               end else if (tick) begin
                  dac_data_nxt = out_sample;
                  if (last_phase) begin
                     k_nxt    = '0;
                     prev_nxt = cur;
                     if (nxt_addr > {1'b0, end_r}) begin
                        done_nxt      = 1'b1;
                        player_en_nxt = 1'b0;
                        state_nxt     = ST_IDLE;
                     end else begin
                        addr_nxt  = nxt_addr[ADDR_W-1:0];
                        state_nxt = ST_FETCH;
                     end
                  end else begin
                     k_nxt = k + 3'd1;
                  end
               end
            end
            ST_PAUSE: begin
               player_en_nxt = 1'b0;
               if (i_start && !i_pause) begin
                  speed_nxt     = i_speed;
                  fast_nxt      = i_fast;
                  interp_nxt    = i_interp;
                  end_nxt       = i_end_addr;
                  player_en_nxt = 1'b1;
                  state_nxt     = ST_WAIT;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign o_rd_req    = (state == ST_FETCH);
   assign o_rd_addr   = addr;
   assign o_player_en = player_en;
   assign o_dac_data  = dac_data;
   assign o_done      = done;
   assign o_state     = state;

endmodule

// File: tb/tb_aud_play_ctrl.sv
// tb/tb_aud_play_ctrl.sv - directed self-checking bench for aud_play_ctrl
module tb_aud_play_ctrl;

   logic        i_bclk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_daclrck = 1'b0;
   logic        i_start = 1'b0;
   logic        i_pause = 1'b0;
   logic        i_stop = 1'b0;
   logic [1:0]  i_speed = 2'd0;
   logic        i_fast = 1'b0;
   logic        i_interp = 1'b0;
   logic [19:0] i_end_addr = 20'd0;
   logic        o_rd_req;
   logic [19:0] o_rd_addr;
   logic        i_rd_valid = 1'b0;
   logic [15:0] i_rd_data = 16'd0;
   logic        o_player_en;
   logic [15:0] o_dac_data;
   logic        o_done;
   logic [1:0]  o_state;

   int          n_checks = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   logic [4:0]  lr_cnt = 5'd0;
   bit          auto_mem = 1'b1;
   int          lat = 2;
   int          cnt = 0;
   int          cyc = 0;
   int          man_at = -1;
   logic [15:0] man_data = 16'd0;
   logic [19:0] rd_log[$];
   logic [15:0] mem[0:15];

   aud_play_ctrl #(.ADDR_W(20), .DATA_W(16)) dut (
      .i_bclk(i_bclk), .i_rst(i_rst), .i_daclrck(i_daclrck),
      .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
      .i_speed(i_speed), .i_fast(i_fast), .i_interp(i_interp),
      .i_end_addr(i_end_addr), .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
      .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
      .o_player_en(o_player_en), .o_dac_data(o_dac_data),
      .o_done(o_done), .o_state(o_state)
   );

   always #5 i_bclk = ~i_bclk;

   // 32-cycle frame; the rising edge lands when lr_cnt becomes 16.
   always @(negedge i_bclk) begin
      lr_cnt = lr_cnt + 5'd1;
      i_daclrck = lr_cnt[4];
   end

   // SRAM model: answers after lat cycles, or at cycle man_at in manual mode.
   always @(negedge i_bclk) begin
      #1;
      cyc = cyc + 1;
      if (!auto_mem) begin
         cnt = 0;
         i_rd_valid = (cyc == man_at);
         i_rd_data = man_data;
      end else if (i_rd_valid) begin
         i_rd_valid = 1'b0;
         cnt = 0;
      end else if (o_rd_req) begin
         if (cnt >= lat) begin
            i_rd_valid = 1'b1;
            i_rd_data = mem[o_rd_addr[3:0]];
            rd_log.push_back(o_rd_addr);
         end else begin
            cnt = cnt + 1;
         end
      end else begin
         cnt = 0;
      end
   end

   always @(negedge i_bclk) begin
      if (o_done === 1'b1) done_cnt = done_cnt + 1;
   end

   task automatic wait_tick();
      for (int i = 0; i < 40; i++) begin
         @(posedge i_bclk);
         if (lr_cnt == 5'd16) break;
      end
      @(negedge i_bclk);
   endtask

   task automatic wait_state(input logic [1:0] st, input string nm);
      for (int i = 0; i < 100; i++) begin
         if (o_state === st) break;
         @(negedge i_bclk);
      end
      n_checks++;
      if (o_state !== st) begin
         n_fail++;
         $display("FAIL %s: state %0d expected %0d", nm, o_state, st);
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
      auto_mem = 1'b1; lat = 2;
      repeat (2) @(negedge i_bclk);
      i_rst = 1'b0;
      @(negedge i_bclk);
   endtask

   task automatic start_play(input logic [1:0] s, input logic f, input logic it,
                             input logic [19:0] e);
      wait_tick();
      i_speed = s; i_fast = f; i_interp = it; i_end_addr = e;
      i_start = 1'b1;
      @(negedge i_bclk);
      i_start = 1'b0;
   endtask

   task automatic load_ramp();
      for (int i = 0; i < 16; i++) mem[i] = 16'(i + 1);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (o_state !== 2'd0 || o_rd_req !== 1'b0 || o_player_en !== 1'b0 ||
          o_dac_data !== 16'd0 || o_done !== 1'b0 || o_rd_addr !== 20'd0) begin
         n_fail++;
         $display("FAIL reset: st=%0d req=%0b en=%0b data=%h done=%0b addr=%h required all 0",
                  o_state, o_rd_req, o_player_en, o_dac_data, o_done, o_rd_addr);
      end
   endtask

   task automatic test_normal_1x();
      int d0, l0;
      bit ok;
      do_reset();
      load_ramp();
      d0 = done_cnt; l0 = rd_log.size();
      start_play(2'd0, 1'b1, 1'b0, 20'd3);
      for (int i = 0; i < 4; i++) begin
         wait_tick();
         n_checks++;
         if (o_dac_data !== 16'(i + 1)) begin
            n_fail++;
            $display("FAIL normal_data[%0d]: got %h expected %h", i, o_dac_data, 16'(i + 1));
         end
      end
      n_checks++;
      if (o_done !== 1'b1 || o_state !== 2'd0 || o_player_en !== 1'b0) begin
         n_fail++;
         $display("FAIL normal_end: done=%0b st=%0d en=%0b expected 1 0 0", o_done, o_state, o_player_en);
      end
      repeat (4) @(negedge i_bclk);
      n_checks++;
      if (done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL normal_done_count: got %0d expected 1", done_cnt - d0);
      end
      ok = (rd_log.size() == l0 + 4);
      for (int i = 0; i < 4; i++) if (ok && rd_log[l0 + i] !== 20'(i)) ok = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL normal_addrs: %0d reads logged, expected 0,1,2,3", rd_log.size() - l0);
      end
   endtask

   task automatic test_fast_4x();
      int l0;
      bit ok;
      logic [15:0] exp_d[3];
      logic [19:0] exp_a[3];
      exp_d = '{16'h0010, 16'h0014, 16'h0018};
      exp_a = '{20'd0, 20'd4, 20'd8};
      do_reset();
      for (int i = 0; i < 16; i++) mem[i] = 16'h00EE;
      mem[0] = 16'h0010; mem[4] = 16'h0014; mem[8] = 16'h0018;
      l0 = rd_log.size();
      start_play(2'd2, 1'b1, 1'b0, 20'd10);
      for (int i = 0; i < 3; i++) begin
         wait_tick();
         n_checks++;
         if (o_dac_data !== exp_d[i]) begin
            n_fail++;
            $display("FAIL fast4_data[%0d]: got %h expected %h", i, o_dac_data, exp_d[i]);
         end
      end
      n_checks++;
      if (o_done !== 1'b1 || o_state !== 2'd0) begin
         n_fail++;
         $display("FAIL fast4_end: done=%0b st=%0d expected 1 0", o_done, o_state);
      end
      ok = (rd_log.size() == l0 + 3);
      for (int i = 0; i < 3; i++) if (ok && rd_log[l0 + i] !== exp_a[i]) ok = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL fast4_addrs: %0d reads logged, expected 0,4,8", rd_log.size() - l0);
      end
   endtask

   // Two samples, slow 4x, end_addr=1: eight ticks then done. exp[7] is the first tick.
   task automatic test_slow_case(input string nm, input logic it, input logic [15:0] m0,
                                 input logic [15:0] m1, input logic [7:0][15:0] exp);
      do_reset();
      mem[0] = m0; mem[1] = m1;
      start_play(2'd2, 1'b0, it, 20'd1);
      for (int i = 0; i < 8; i++) begin
         wait_tick();
         n_checks++;
         if (o_dac_data !== exp[7 - i]) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, i, o_dac_data, exp[7 - i]);
         end
      end
      n_checks++;
      if (o_done !== 1'b1 || o_state !== 2'd0) begin
         n_fail++;
         $display("FAIL %s_end: done=%0b st=%0d expected 1 0", nm, o_done, o_state);
      end
   endtask

   task automatic test_pause_wait();
      int l0;
      bit ok;
      do_reset();
      load_ramp();
      l0 = rd_log.size();
      start_play(2'd0, 1'b1, 1'b0, 20'd3);
      wait_tick();
      wait_state(2'd2, "pw_reach_wait");
      i_pause = 1'b1;
      @(negedge i_bclk);
      i_pause = 1'b0;
      n_checks++;
      if (o_state !== 2'd3 || o_player_en !== 1'b0 || o_dac_data !== 16'h0001) begin
         n_fail++;
         $display("FAIL pw_paused: st=%0d en=%0b data=%h expected 3 0 0001", o_state, o_player_en, o_dac_data);
      end
      wait_tick();
      n_checks++;
      if (o_state !== 2'd3 || o_dac_data !== 16'h0001) begin
         n_fail++;
         $display("FAIL pw_held: st=%0d data=%h expected 3 0001", o_state, o_dac_data);
      end
      i_start = 1'b1;
      @(negedge i_bclk);
      i_start = 1'b0;
      n_checks++;
      if (o_state !== 2'd2 || o_player_en !== 1'b1) begin
         n_fail++;
         $display("FAIL pw_resume: st=%0d en=%0b expected 2 1", o_state, o_player_en);
      end
      for (int i = 2; i <= 4; i++) begin
         wait_tick();
         n_checks++;
         if (o_dac_data !== 16'(i)) begin
            n_fail++;
            $display("FAIL pw_data[%0d]: got %h expected %h", i, o_dac_data, 16'(i));
         end
      end
      repeat (2) @(negedge i_bclk);
      ok = (rd_log.size() == l0 + 4) && (o_state === 2'd0);
      for (int i = 0; i < 4; i++) if (ok && rd_log[l0 + i] !== 20'(i)) ok = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL pw_addrs: %0d reads, st=%0d expected 0,1,2,3 then idle", rd_log.size() - l0, o_state);
      end
   endtask

   task automatic test_pause_fetch();
      do_reset();
      auto_mem = 1'b0;
      man_data = 16'h0055;
      start_play(2'd0, 1'b1, 1'b0, 20'd3);
      i_pause = 1'b1;
      man_at = cyc + 4;
      @(negedge i_bclk);
      i_pause = 1'b0;
      n_checks++;
      if (o_state !== 2'd1 || o_rd_req !== 1'b1 || o_rd_addr !== 20'd0) begin
         n_fail++;
         $display("FAIL pf_pending: st=%0d req=%0b addr=%h expected 1 1 0", o_state, o_rd_req, o_rd_addr);
      end
      wait_state(2'd3, "pf_pause_on_valid");
      n_checks++;
      if (o_rd_req !== 1'b0 || o_player_en !== 1'b0) begin
         n_fail++;
         $display("FAIL pf_paused: req=%0b en=%0b expected 0 0", o_rd_req, o_player_en);
      end
      i_start = 1'b1;
      @(negedge i_bclk);
      i_start = 1'b0;
      wait_tick();
      n_checks++;
      if (o_dac_data !== 16'h0055 || o_state !== 2'd1 || o_rd_addr !== 20'd1) begin
         n_fail++;
         $display("FAIL pf_resume: data=%h st=%0d addr=%h expected 0055 1 1", o_dac_data, o_state, o_rd_addr);
      end
      i_stop = 1'b1;
      @(negedge i_bclk);
      i_stop = 1'b0;
   endtask

   task automatic test_stop_fetch();
      int d0;
      do_reset();
      load_ramp();
      start_play(2'd0, 1'b1, 1'b0, 20'd3);
      wait_state(2'd2, "sf_reach_wait");
      auto_mem = 1'b0;
      man_data = 16'hBEEF;
      wait_tick();
      n_checks++;
      if (o_dac_data !== 16'h0001 || o_state !== 2'd1 || o_rd_req !== 1'b1 || o_rd_addr !== 20'd1) begin
         n_fail++;
         $display("FAIL sf_fetching: data=%h st=%0d req=%0b addr=%h expected 0001 1 1 1",
                  o_dac_data, o_state, o_rd_req, o_rd_addr);
      end
      d0 = done_cnt;
      i_stop = 1'b1;
      man_at = cyc + 4;
      @(negedge i_bclk);
      i_stop = 1'b0;
      n_checks++;
      if (o_rd_req !== 1'b0 || o_state !== 2'd0 || o_dac_data !== 16'd0 ||
          o_player_en !== 1'b0 || o_rd_addr !== 20'd0) begin
         n_fail++;
         $display("FAIL sf_stopped: req=%0b st=%0d data=%h en=%0b addr=%h expected all 0",
                  o_rd_req, o_state, o_dac_data, o_player_en, o_rd_addr);
      end
      repeat (6) @(negedge i_bclk);
      n_checks++;
      if (o_state !== 2'd0 || o_dac_data !== 16'd0 || o_rd_req !== 1'b0 || done_cnt != d0) begin
         n_fail++;
         $display("FAIL sf_late_valid: st=%0d data=%h req=%0b dones=%0d expected 0 0 0 0",
                  o_state, o_dac_data, o_rd_req, done_cnt - d0);
      end
   endtask

   task automatic test_slow_sram();
      int l0;
      bit ok;
      logic [15:0] exp_d[8];
      exp_d = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd4};
      do_reset();
      load_ramp();
      lat = 40;
      l0 = rd_log.size();
      start_play(2'd0, 1'b1, 1'b0, 20'd3);
      for (int i = 0; i < 8; i++) begin
         wait_tick();
         n_checks++;
         if (o_dac_data !== exp_d[i]) begin
            n_fail++;
            $display("FAIL slowsram_data[%0d]: got %h expected %h", i, o_dac_data, exp_d[i]);
         end
      end
      n_checks++;
      if (o_done !== 1'b1 || o_state !== 2'd0) begin
         n_fail++;
         $display("FAIL slowsram_end: done=%0b st=%0d expected 1 0", o_done, o_state);
      end
      ok = (rd_log.size() == l0 + 4);
      for (int i = 0; i < 4; i++) if (ok && rd_log[l0 + i] !== 20'(i)) ok = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL slowsram_addrs: %0d reads logged, expected 0,1,2,3", rd_log.size() - l0);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      load_ramp();
      start_play(2'd0, 1'b1, 1'b0, 20'd3);
      wait_tick();
      wait_state(2'd2, "rm_reach_wait");
      n_checks++;
      if (o_dac_data !== 16'h0001 || o_player_en !== 1'b1) begin
         n_fail++;
         $display("FAIL rm_before: data=%h en=%0b expected 0001 1", o_dac_data, o_player_en);
      end
      i_rst = 1'b1;
      #1;
      n_checks++;
      if (o_state !== 2'd0 || o_dac_data !== 16'd0 || o_player_en !== 1'b0 ||
          o_rd_req !== 1'b0 || o_rd_addr !== 20'd0 || o_done !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_async: st=%0d data=%h en=%0b req=%0b addr=%h done=%0b expected all 0",
                  o_state, o_dac_data, o_player_en, o_rd_req, o_rd_addr, o_done);
      end
      @(negedge i_bclk);
      i_rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_normal_1x();
      test_fast_4x();
      test_slow_case("interp_up", 1'b1, 16'h0000, 16'h0100,
                     {16'h0000, 16'h0000, 16'h0000, 16'h0000,
                      16'h0000, 16'h0040, 16'h0080, 16'h00C0});
      test_slow_case("repeat", 1'b0, 16'h0000, 16'h0100,
                     {16'h0000, 16'h0000, 16'h0000, 16'h0000,
                      16'h0100, 16'h0100, 16'h0100, 16'h0100});
      test_slow_case("interp_neg", 1'b1, 16'h0100, 16'hFF00,
                     {16'h0000, 16'h0040, 16'h0080, 16'h00C0,
                      16'h0100, 16'h0080, 16'h0000, 16'hFF80});
      test_pause_wait();
      test_pause_fetch();
      test_stop_fetch();
      test_slow_sram();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
